// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store front end for a word-organised data memory.
//   Loads complete in one cycle. Word stores write directly. Byte/half stores are
//   done as read-modify-write: one read cycle (stall high), then one write cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : request (valid, load/store, size, signed, byte addr, store data)
//   dm_*              : data memory (word address, read/write strobes, write data,
//                       combinational read data)
//   stall             : hold upstream for the read phase of a sub-word store
//   rsp_valid/rdata   : registered load result
//   err               : registered one-cycle fault pulse
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [6:0]  dm_address,
  output logic        dm_memRead,
  output logic        dm_memWrite,
  output logic [31:0] dm_writeData,
  input  logic [31:0] dm_readData,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state, state_next;
  logic [31:0] merge_q, merge_next;
  logic [6:0]  addr_q;
  logic [31:0] load_data;
  logic        fault, accept, do_load, do_store_word, do_store_sub;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    fault = (req_load && req_store)
         || (req_size == 2'b11)
         || (req_size == 2'b01 && req_addr[0])
         || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    accept        = (state == IDLE) && req_valid && !rst;
    do_load       = accept && !fault && req_load;
    do_store_word = accept && !fault && req_store && (req_size == 2'b10);
    do_store_sub  = accept && !fault && req_store && (req_size != 2'b10);
  end

  // Lane extraction for loads.
  always_comb begin
    lane_b = '0;
    case (req_addr[1:0])
      2'd0: lane_b = dm_readData[7:0];
      2'd1: lane_b = dm_readData[15:8];
      2'd2: lane_b = dm_readData[23:16];
      default: lane_b = dm_readData[31:24];
    endcase
    lane_h = req_addr[1] ? dm_readData[31:16] : dm_readData[15:0];
    case (req_size)
      2'b00:   load_data = {{24{req_signed & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{req_signed & lane_h[15]}}, lane_h};
      default: load_data = dm_readData;
    endcase
  end

  // Merge of store data into the word read during the first RMW cycle.
  always_comb begin
    merge_next = dm_readData;
    if (req_size == 2'b01) begin
      if (req_addr[1]) merge_next[31:16] = req_wdata[15:0];
      else             merge_next[15:0]  = req_wdata[15:0];
    end else begin
      case (req_addr[1:0])
        2'd0: merge_next[7:0]   = req_wdata[7:0];
        2'd1: merge_next[15:8]  = req_wdata[7:0];
        2'd2: merge_next[23:16] = req_wdata[7:0];
        default: merge_next[31:24] = req_wdata[7:0];
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    dm_address   = req_addr[8:2];
    dm_memRead   = 1'b0;
    dm_memWrite  = 1'b0;
    dm_writeData = req_wdata;
    stall        = 1'b0;
    case (state)
      IDLE: begin
        if (do_load)       dm_memRead  = 1'b1;
        if (do_store_word) dm_memWrite = 1'b1;
        if (do_store_sub) begin
          dm_memRead = 1'b1;
          stall      = 1'b1;
          state_next = RMW_WR;
        end
      end
      RMW_WR: begin
        dm_address   = addr_q;
        dm_writeData = merge_q;
        // Reset during the write cycle drops the write entirely.
        dm_memWrite  = !rst;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
      merge_q   <= '0;
      addr_q    <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= do_load;
      err       <= accept && fault;
      if (do_load) rsp_rdata <= load_data;
      if (do_store_sub) begin
        merge_q <= merge_next;
        addr_q  <= req_addr[8:2];
      end
    end
  end

endmodule
